// File: rtl/i2c_target_regs.sv
// I2C target serving a byte register bank with pointer auto-increment.
// Optional SCL/SDA glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regs #(
  parameter logic [6:0] ADDRESS = 7'h38,
  parameter int N_REGS = 16,
  localparam int PTR_W = $clog2(N_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic             reg_wr_ena,
  input  logic [PTR_W-1:0] reg_wr_addr,
  input  logic [7:0]       reg_wr_data,
  output logic             rx_valid,
  output logic [PTR_W-1:0] rx_addr,
  output logic [7:0]       rx_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f;
  logic       scl_q, sda_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;
  logic       scl_fq, sda_fq;

  // Accept a level once it has been seen on three consecutive samples.
  always_comb begin
    scl_f = scl_fq;
    sda_f = sda_fq;
    if (scl_sync[1] == scl_h[0] && scl_sync[1] == scl_h[1])
      scl_f = scl_sync[1];
    if (sda_sync[1] == sda_h[0] && sda_sync[1] == sda_h[1])
      sda_f = sda_sync[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_h  <= 2'b11;
      sda_h  <= 2'b11;
      scl_fq <= 1'b1;
      sda_fq <= 1'b1;
    end else begin
      scl_h  <= {scl_h[0], scl_sync[1]};
      sda_h  <= {sda_h[0], sda_sync[1]};
      scl_fq <= scl_f;
      sda_fq <= sda_f;
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_c, stop_c;

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;

  state_t           state, state_d;
  logic [7:0]       sr, sr_d;
  logic [2:0]       cnt, cnt_d;
  logic [PTR_W-1:0] ptr, ptr_d;
  logic             rw, rw_d;
  logic             ack_on, ack_d;
  logic             oe_d, busy_d, commit;
  logic [7:0]       byte_in;
  logic [7:0]       regs [N_REGS];

  assign byte_in = {sr[6:0], sda_f};

  always_comb begin
    state_d = state;
    sr_d    = sr;
    cnt_d   = cnt;
    ptr_d   = ptr;
    rw_d    = rw;
    ack_d   = ack_on;
    oe_d    = sda_oe;
    busy_d  = busy;
    commit  = 1'b0;
    if (stop_c) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = 3'd0;
      ack_d   = 1'b0;
    end else if (start_c) begin
      state_d = ADDR;
      oe_d    = 1'b0;
      cnt_d   = 3'd0;
      ack_d   = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR, PTR, WDATA: begin
          if (scl_fall)
            oe_d = 1'b0;
          if (scl_rise) begin
            sr_d  = byte_in;
            cnt_d = cnt + 3'd1;
            if (cnt == 3'd7) begin
              ack_d = 1'b0;
              if (state == ADDR) begin
                if (byte_in[7:1] == ADDRESS) begin
                  state_d = ADDR_ACK;
                  rw_d    = byte_in[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = IDLE;
                end
              end else if (state == PTR) begin
                ptr_d   = byte_in[PTR_W-1:0];
                state_d = PTR_ACK;
              end else begin
                commit  = 1'b1;
                ptr_d   = ptr + 1'b1;
                state_d = WDATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          // ACK is held low from one SCL fall through the next rise.
          if (scl_fall && !ack_on) begin
            oe_d  = 1'b1;
            ack_d = 1'b1;
          end else if (scl_rise && ack_on) begin
            ack_d = 1'b0;
            cnt_d = 3'd0;
            if (state == ADDR_ACK && rw) begin
              sr_d    = regs[ptr];
              state_d = RDATA;
            end else if (state == ADDR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            oe_d = ~sr[7];
            sr_d = {sr[6:0], 1'b0};
          end else if (scl_rise) begin
            cnt_d = cnt + 3'd1;
            if (cnt == 3'd7) begin
              ptr_d   = ptr + 1'b1;
              state_d = RACK;
            end
          end
        end
        RACK: begin
          if (scl_fall) begin
            oe_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda_f) begin
              sr_d    = regs[ptr];
              cnt_d   = 3'd0;
              state_d = RDATA;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= 8'h00;
      cnt      <= 3'd0;
      ptr      <= '0;
      rw       <= 1'b0;
      ack_on   <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_addr  <= '0;
      rx_data  <= 8'h00;
    end else begin
      state    <= state_d;
      sr       <= sr_d;
      cnt      <= cnt_d;
      ptr      <= ptr_d;
      rw       <= rw_d;
      ack_on   <= ack_d;
      sda_oe   <= oe_d;
      busy     <= busy_d;
      rx_valid <= commit;
      if (commit) begin
        rx_addr <= ptr;
        rx_data <= byte_in;
      end
    end
  end

  // A bus commit to the same index beats a simultaneous local write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REGS; i++) begin
      if (rst)
        regs[i] <= 8'h00;
      else if (commit && ptr == PTR_W'(i))
        regs[i] <= byte_in;
      else if (reg_wr_ena && reg_wr_addr == PTR_W'(i))
        regs[i] <= reg_wr_data;
    end
  end

endmodule
